// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with stall, relative branch (one flush bubble),
// halt and a saturating execution-cycle counter.
module pc_sequencer #(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [D-1:0]  offset,
    input  logic          halt,
    output logic [D-1:0]  pc,
    output logic          fetch_valid,
    output logic          flush,
    output logic          done,
    output logic [CW-1:0] cycle_count
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nxt;
    logic launch, live, advance, counting;
    assign launch   = start && (state == IDLE || state == DONE);
    assign live     = state == RUN && !stall;
    assign advance  = live && !halt;
    assign counting = live || state == FLUSH;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    always_comb
        state_nxt = launch          ? RUN :
                    state == FLUSH  ? RUN :
                    live            ? (halt ? DONE : branch_taken ? FLUSH : RUN) :
                                      state;
    // Offset is two's complement, so a plain D-bit add wraps modulo 2^D for either sign.
    always_ff @(posedge clk or posedge reset)
        if (reset)        pc <= '0;
        else if (launch)  pc <= start_addr;
        else if (advance) pc <= pc + (branch_taken ? offset : D'(1));
    always_ff @(posedge clk or posedge reset)
        if (reset)                              cycle_count <= '0;
        else if (launch)                        cycle_count <= '0;
        else if (counting && cycle_count != '1) cycle_count <= cycle_count + CW'(1);
    always_comb begin
        fetch_valid = state == RUN;
        flush       = state == FLUSH;
        done        = state == DONE;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus against a cycle-level behavioural model plus literal checks.
module tb_pc_sequencer;
    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;
    logic clk, reset, start, stall, branch_taken, halt;
    logic [11:0] start_addr, offset, pc;
    logic fetch_valid, flush, done;
    logic [CW-1:0] cycle_count;
    int vectors, miscompares;
    int m_mode, m_pc, m_cnt;

    pc_sequencer #(.D(12), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .stall(stall), .branch_taken(branch_taken), .offset(offset), .halt(halt),
        .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .done(done),
        .cycle_count(cycle_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        check("model pc", 32'(pc), m_pc);
        check("model fetch_valid", 32'(fetch_valid), 32'(m_mode == 1));
        check("model flush", 32'(flush), 32'(m_mode == 2));
        check("model done", 32'(done), 32'(m_mode == 3));
        check("model cycle_count", 32'(cycle_count), m_cnt);
    endtask

    // Modes: 0 idle, 1 run, 2 flush, 3 done.
    task automatic step();
        if (reset) begin
            m_mode = 0; m_pc = 0; m_cnt = 0;
        end else if ((m_mode == 0 || m_mode == 3) && start) begin
            m_mode = 1; m_pc = int'(start_addr); m_cnt = 0;
        end else if (m_mode == 2) begin
            m_mode = 1; m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else if (m_mode == 1 && !stall) begin
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            if (halt) m_mode = 3;
            else if (branch_taken) begin
                m_pc = (m_pc + int'(offset)) % 4096; m_mode = 2;
            end else m_pc = (m_pc + 1) % 4096;
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic branch(input logic [11:0] off);
        branch_taken = 1; offset = off;
        step();
        branch_taken = 0;
    endtask

    task automatic launch(input logic [11:0] addr);
        start = 1; start_addr = addr;
        step();
        start = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1; start = 0; start_addr = 0; stall = 0;
        branch_taken = 0; offset = 0; halt = 0;
        m_mode = 0; m_pc = 0; m_cnt = 0;
        step(); step();
        reset = 0;
        step();
        check("idle pc", 32'(pc), 0);
        check("idle fetch_valid", 32'(fetch_valid), 0);
        launch(12'h010);
        check("start pc", 32'(pc), 32'h010);
        check("start fetch_valid", 32'(fetch_valid), 1);
        check("start count", 32'(cycle_count), 0);
        repeat (3) step();
        check("free pc", 32'(pc), 32'h013);
        check("free count", 32'(cycle_count), 3);
        repeat (13) step();
        check("pre-branch pc", 32'(pc), 32'h020);
        branch(12'hFFB);
        check("flush pc", 32'(pc), 32'h01B);
        check("flush flag", 32'(flush), 1);
        check("flush fetch_valid", 32'(fetch_valid), 0);
        step();
        check("target pc", 32'(pc), 32'h01B);
        check("target fetch_valid", 32'(fetch_valid), 1);
        check("branch count", 32'(cycle_count), 18);
        branch(12'h015);
        step();
        check("stall setup pc", 32'(pc), 32'h030);
        stall = 1; branch_taken = 1; halt = 1;
        repeat (3) begin
            step();
            check("stall pc", 32'(pc), 32'h030);
            check("stall fetch_valid", 32'(fetch_valid), 1);
            check("stall count", 32'(cycle_count), 20);
        end
        stall = 0;
        step();
        halt = 0; branch_taken = 0;
        check("halt done", 32'(done), 1);
        check("halt pc", 32'(pc), 32'h030);
        check("halt count", 32'(cycle_count), 21);
        step();
        check("done hold count", 32'(cycle_count), 21);
        launch(12'h100);
        check("restart pc", 32'(pc), 32'h100);
        check("restart count", 32'(cycle_count), 0);
        check("restart fetch_valid", 32'(fetch_valid), 1);
        launch(12'h555);
        check("start in run ignored", 32'(pc), 32'h101);
        branch(12'hEFE);
        step();
        check("wrap setup pc", 32'(pc), 32'hFFF);
        step();
        check("wrap pc", 32'(pc), 32'h000);
        branch(12'hFFE);
        step();
        check("fwd setup pc", 32'(pc), 32'hFFE);
        branch(12'h005);
        check("fwd wrap pc", 32'(pc), 32'h003);
        step();
        repeat (40) step();
        check("saturated count", 32'(cycle_count), CMAX);
        halt = 1;
        step();
        halt = 0;
        check("done again", 32'(done), 1);
        launch(12'h040);
        branch(12'h010);
        check("mid flush flag", 32'(flush), 1);
        #3;
        reset = 1;
        m_mode = 0; m_pc = 0; m_cnt = 0;
        #1;
        check("async reset pc", 32'(pc), 0);
        check("async reset flush", 32'(flush), 0);
        check("async reset fetch_valid", 32'(fetch_valid), 0);
        check("async reset done", 32'(done), 0);
        check("async reset count", 32'(cycle_count), 0);
        step();
        reset = 0;
        step();
        check("post reset idle", 32'(fetch_valid), 0);
        launch(12'h040);
        check("post reset start pc", 32'(pc), 32'h040);
        step();
        check("post reset run pc", 32'(pc), 32'h041);
        check("post reset count", 32'(cycle_count), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
